// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and helpers for the SR latch controller: FSM states, operation
// codes and the latch readback payload.
package sr_latch_ctrl_pkg;

  localparam int unsigned PULSE_CYC_DEF = 4;
  localparam int unsigned GUARD_CYC_DEF = 2;
  localparam int unsigned CNT_W_DEF     = 8;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_PULSE = 3'd2,
    ST_GUARD = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_e;

  typedef struct packed {
    logic q;
    logic qn;
  } latch_fb_t;

  // Readback is good only when Q matches the operation and Qn is its complement.
  function automatic logic fb_matches(input op_e op, input latch_fb_t fb);
    return (fb.q == logic'(op)) && (fb.qn != fb.q);
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the pulse and guard phases; holds at zero
// instead of wrapping.
module sr_pulse_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequences an external NOR SR latch for a set and a clear requester: timed,
// mutually exclusive S/R pulses, a guard gap, then readback verification.
module sr_latch_ctrl
  import sr_latch_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_CYC = PULSE_CYC_DEF,
  parameter int unsigned GUARD_CYC = GUARD_CYC_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic err_clr,
  input  logic q_fb,
  input  logic qn_fb,
  output logic latch_s,
  output logic latch_r,
  output logic set_ack,
  output logic clr_ack,
  output logic busy,
  output logic done,
  output logic err,
  output logic q_state
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC - 1);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  op_e    last_op_q, last_op_d;
  logic   forced_q, forced_d;
  logic   latch_s_q, latch_s_d;
  logic   latch_r_q, latch_r_d;
  logic   set_ack_q, set_ack_d;
  logic   clr_ack_q, clr_ack_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   q_state_q, q_state_d;

  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             tmr_zero_c;
  latch_fb_t        fb_c;

  assign fb_c = {q_fb, qn_fb};

  sr_pulse_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load_c),
    .load_val_i(tmr_val_c),
    .zero_c    (tmr_zero_c)
  );

  // Next-state, timer control and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    last_op_d  = last_op_q;
    forced_d   = forced_q;
    q_state_d  = q_state_q;
    err_d      = err_q & ~err_clr;
    set_ack_d  = 1'b0;
    clr_ack_d  = 1'b0;
    done_d     = 1'b0;
    tmr_load_c = 1'b0;
    tmr_val_c  = PULSE_LD;

    case (state_q)
      ST_INIT: begin
        // Latch content is unknown after power-up, so force a clear.
        state_d    = ST_PULSE;
        op_d       = OP_CLR;
        forced_d   = 1'b1;
        tmr_load_c = 1'b1;
      end
      ST_IDLE: begin
        if (set_req || clr_req) begin
          if (set_req && clr_req) begin
            op_d = (last_op_q == OP_SET) ? OP_CLR : OP_SET;
          end else begin
            op_d = set_req ? OP_SET : OP_CLR;
          end
          state_d    = ST_PULSE;
          tmr_load_c = 1'b1;
          set_ack_d  = (op_d == OP_SET);
          clr_ack_d  = (op_d == OP_CLR);
        end
      end
      ST_PULSE: begin
        if (tmr_zero_c) begin
          state_d    = ST_GUARD;
          tmr_load_c = 1'b1;
          tmr_val_c  = GUARD_LD;
        end
      end
      ST_GUARD: begin
        if (tmr_zero_c) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (fb_matches(op_q, fb_c)) begin
          q_state_d = (op_q == OP_SET);
        end else begin
          err_d = 1'b1;
        end
        // The forced clear has no requester, so it does not move the round-robin.
        if (!forced_q) begin
          last_op_d = op_q;
        end
        forced_d = 1'b0;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    latch_s_d = (state_d == ST_PULSE) && (op_d == OP_SET);
    latch_r_d = (state_d == ST_PULSE) && (op_d == OP_CLR);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      op_q      <= OP_CLR;
      last_op_q <= OP_SET;
      forced_q  <= 1'b0;
      latch_s_q <= 1'b0;
      latch_r_q <= 1'b0;
      set_ack_q <= 1'b0;
      clr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      q_state_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      last_op_q <= last_op_d;
      forced_q  <= forced_d;
      latch_s_q <= latch_s_d;
      latch_r_q <= latch_r_d;
      set_ack_q <= set_ack_d;
      clr_ack_q <= clr_ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      q_state_q <= q_state_d;
    end
  end

  assign latch_s = latch_s_q;
  assign latch_r = latch_r_q;
  assign set_ack = set_ack_q;
  assign clr_ack = clr_ack_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign q_state = q_state_q;

  // S=R=1 is the forbidden latch input and must never be driven.
  a_mutex: assert property (@(posedge clk) !(latch_s_q && latch_r_q));

  a_set_ack_in_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    set_ack_q |-> latch_s_q);

  a_clr_ack_in_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    clr_ack_q |-> latch_r_q);

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Scoreboard bench for sr_latch_ctrl: a behavioural latch drives readback,
// expectations are queued at stimulus time and checked by a monitor.
module tb_sr_latch_ctrl;

  localparam int P = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rst_n, set_req, clr_req, err_clr, q_fb, qn_fb;
  logic latch_s, latch_r, set_ack, clr_ack, busy, done, err, q_state;

  logic f_rst_n, f_set_req, f_clr_req, f_err_clr, f_q_fb, f_qn_fb;
  logic f_latch_s, f_latch_r, f_set_ack, f_clr_ack, f_busy, f_done, f_err, f_q_state;

  sr_latch_ctrl #(.PULSE_CYC(P), .GUARD_CYC(G), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req),
    .err_clr(err_clr), .q_fb(q_fb), .qn_fb(qn_fb), .latch_s(latch_s),
    .latch_r(latch_r), .set_ack(set_ack), .clr_ack(clr_ack), .busy(busy),
    .done(done), .err(err), .q_state(q_state)
  );

  sr_latch_ctrl #(.PULSE_CYC(1), .GUARD_CYC(1), .CNT_W(8)) u_fast (
    .clk(clk), .rst_n(f_rst_n), .set_req(f_set_req), .clr_req(f_clr_req),
    .err_clr(f_err_clr), .q_fb(f_q_fb), .qn_fb(f_qn_fb), .latch_s(f_latch_s),
    .latch_r(f_latch_r), .set_ack(f_set_ack), .clr_ack(f_clr_ack), .busy(f_busy),
    .done(f_done), .err(f_err), .q_state(f_q_state)
  );

  // Behavioural NOR latches; stuck forces both readbacks low.
  bit lq, flq, stuck;
  always @(negedge clk) begin
    if (latch_s) lq = 1'b1;
    else if (latch_r) lq = 1'b0;
    if (f_latch_s) flq = 1'b1;
    else if (f_latch_r) flq = 1'b0;
  end
  assign q_fb    = stuck ? 1'b0 : lq;
  assign qn_fb   = stuck ? 1'b0 : ~lq;
  assign f_q_fb  = flq;
  assign f_qn_fb = ~flq;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { bit op; bit q; bit e; } done_exp_t;
  done_exp_t done_q[$];
  bit        ack_q[$];

  bit model_q, model_err, last_op;

  // Queue what a request should produce: ack kind, then the done readback result.
  function automatic void expect_op(input bit op);
    ack_q.push_back(op);
    if (stuck) model_err = 1'b1;
    else model_q = op;
    last_op = op;
    done_q.push_back('{op, model_q, model_err});
  endfunction

  int        cnt_s, cnt_r, first_pulse;
  done_exp_t d;
  bit        e;

  // Monitor: pops expectations whenever the DUT acks or reports done.
  always @(negedge clk) begin
    check("mutex", int'(latch_s & latch_r), 0);
    check("fast_mutex", int'(f_latch_s & f_latch_r), 0);
    if (!rst_n) begin
      cnt_s = 0;
      cnt_r = 0;
    end else begin
      if ((latch_s || latch_r) && cnt_s == 0 && cnt_r == 0) first_pulse = cyc;
      if (latch_s) cnt_s++;
      if (latch_r) cnt_r++;
      if (set_ack || clr_ack) begin
        check("ack_expected", int'(ack_q.size() != 0), 1);
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("ack_kind", int'({set_ack, clr_ack}), e ? 2 : 1);
        end
      end
      if (done) begin
        check("done_expected", int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check("pulse_len", d.op ? cnt_s : cnt_r, P);
          check("other_pulse", d.op ? cnt_r : cnt_s, 0);
          check("latency", cyc - first_pulse, P + G + 1);
          check("q_state", int'(q_state), int'(d.q));
          check("err", int'(err), int'(d.e));
          check("busy_at_done", int'(busy), 0);
        end
        cnt_s = 0;
        cnt_r = 0;
      end
    end
  end

  task automatic wait_ev(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && set_ack) || (which == 1 && clr_ack) ||
          (which == 2 && f_set_ack) || (which == 3 && f_clr_ack) ||
          (which == 4 && f_done)) begin
        at = cyc;
        return;
      end
    end
    checks++;
    $display("FAIL wait_ev%0d: event not seen within %0d cycles", which, budget);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack_q.size() == 0 && done_q.size() == 0) return;
    end
    checks++;
    $display("FAIL drain: %0d acks and %0d dones still pending", ack_q.size(), done_q.size());
    ack_q.delete();
    done_q.delete();
  endtask

  // Raise requests, release each after its ack, wait for all results.
  task automatic do_op(input bit s, input bit c);
    bit first;
    int at;
    first = (s && c) ? ~last_op : s;
    expect_op(first);
    if (s && c) expect_op(~first);
    @(posedge clk); #1;
    set_req = s;
    clr_req = c;
    wait_ev(first ? 0 : 1, 40, at);
    @(posedge clk); #1;
    if (first) set_req = 1'b0;
    else clr_req = 1'b0;
    if (s && c) begin
      wait_ev(first ? 1 : 0, 40, at);
      @(posedge clk); #1;
      set_req = 1'b0;
      clr_req = 1'b0;
    end
    wait_drain();
  endtask

  task automatic pulse_err_clr();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    check("err_cleared", int'(err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a1, d1, a2, d2;
    int r;
    rst_n = 1'b0; set_req = 1'b0; clr_req = 1'b0; err_clr = 1'b0;
    f_rst_n = 1'b0; f_set_req = 1'b0; f_clr_req = 1'b0; f_err_clr = 1'b0;
    stuck = 1'b0; lq = 1'b1; flq = 1'b1;
    model_q = 1'b0; model_err = 1'b0; last_op = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({latch_s, latch_r, set_ack, clr_ack, busy, done, err, q_state}), 0);

    // Forced clear after reset release, no ack.
    done_q.push_back('{1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_drain();

    do_op(1'b1, 1'b0);
    do_op(1'b1, 1'b1);

    stuck = 1'b1;
    do_op(1'b1, 1'b0);
    stuck = 1'b0;
    pulse_err_clr();

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 2);
      stuck = ($urandom_range(0, 7) == 0);
      do_op(r != 1, r != 0);
      stuck = 1'b0;
      if ($urandom_range(0, 2) == 0) pulse_err_clr();
    end

    // Reset in the second pulse cycle of a set.
    expect_op(1'b1);
    @(posedge clk); #1;
    set_req = 1'b1;
    wait_ev(0, 40, a1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_latch_s", int'(latch_s), 0);
    check("rst_busy", int'(busy), 0);
    set_req = 1'b0;
    ack_q.delete();
    done_q.delete();
    model_q = 1'b0; model_err = 1'b0; last_op = 1'b1;
    done_q.push_back('{1'b0, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_drain();
    repeat (10) @(negedge clk);
    do_op(1'b1, 1'b1);

    // Minimal timing instance: 3 cycles ack to done, back-to-back service.
    @(posedge clk); #1;
    f_rst_n = 1'b1;
    wait_ev(4, 20, d1);
    check("fast_init_q", int'(f_q_state), 0);
    @(posedge clk); #1;
    f_set_req = 1'b1;
    wait_ev(2, 20, a1);
    @(posedge clk); #1;
    f_set_req = 1'b0;
    f_clr_req = 1'b1;
    wait_ev(4, 20, d1);
    check("fast_set_latency", d1 - a1, 3);
    check("fast_set_q", int'(f_q_state), 1);
    wait_ev(3, 20, a2);
    check("fast_back_to_back", a2 - d1, 1);
    @(posedge clk); #1;
    f_clr_req = 1'b0;
    wait_ev(4, 20, d2);
    check("fast_clr_latency", d2 - a2, 3);
    check("fast_clr_q", int'(f_q_state), 0);
    check("fast_err", int'(f_err), 0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
